// File: rtl/mem_ctrl_sync_pkg.sv
// Shared definitions for mem_ctrl_sync: FSM state encoding and wait-counter width.
// Optional parity support is selected with MEM_CTRL_SYNC_PARITY_EN.
package mem_ctrl_sync_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    XFER
  } state_t;

endpackage

// File: rtl/mem_ctrl_sync_array.sv
// DEPTH x DATA_W storage: synchronous write, combinational read, contents never reset.
// With MEM_CTRL_SYNC_PARITY_EN defined, an even-parity column is stored alongside each word.
module mem_ctrl_sync_array
  import mem_ctrl_sync_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              Clk,
  input  logic              WrEn,
  input  logic [ADDR_W-1:0] WrAddr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [ADDR_W-1:0] RdAddr,
`ifdef MEM_CTRL_SYNC_PARITY_EN
  output logic              RdPar,
`endif
  output logic [DATA_W-1:0] RdData
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              rdInRange;

  assign rdInRange = ({1'b0, RdAddr} < DEPTH_EXT);

  always_ff @(posedge Clk) begin
    if (WrEn) begin
      mem[WrAddr] <= WrData;
    end
  end

  assign RdData = rdInRange ? mem[RdAddr] : '0;

`ifdef MEM_CTRL_SYNC_PARITY_EN
  logic parMem [DEPTH];

  always_ff @(posedge Clk) begin
    if (WrEn) begin
      parMem[WrAddr] <= ^WrData;
    end
  end

  assign RdPar = rdInRange ? parMem[RdAddr] : 1'b0;
`endif

endmodule

// File: rtl/mem_ctrl_sync.sv
// Single-port synchronous memory controller with fixed WAIT_CYC wait states and a shared tristate data bus.
// Define MEM_CTRL_SYNC_PARITY_EN to add per-word even parity and the ParErr output.
module mem_ctrl_sync
  import mem_ctrl_sync_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 6,
  parameter int DEPTH    = 64,
  parameter int WAIT_CYC = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              MemRd,
  input  logic              MemWr,
  input  logic [ADDR_W-1:0] Addr,
  inout  logic [DATA_W-1:0] DataBus,
`ifdef MEM_CTRL_SYNC_PARITY_EN
  output logic              ParErr,
`endif
  output logic              Ready,
  output logic              Busy,
  output logic              ReqErr
);

  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  state_t            state;
  logic [CNT_W-1:0]  waitCnt;
  logic              opWr;
  logic              inRange;
  logic [ADDR_W-1:0] addrLat;
  logic [DATA_W-1:0] wrLat;
  logic [DATA_W-1:0] rdOut;
  logic              driveEn;
  logic              addrOk;
  logic              arrWrEn;
  logic [DATA_W-1:0] arrRdData;
`ifdef MEM_CTRL_SYNC_PARITY_EN
  logic              arrRdPar;
`endif

  assign addrOk  = ({1'b0, Addr} < DEPTH_EXT);
  // Commit is qualified by !Rst so a reset on the XFER edge never writes.
  assign arrWrEn = (state == XFER) && opWr && inRange && !Rst;
  assign DataBus = driveEn ? rdOut : 'z;

  mem_ctrl_sync_array #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) uArray (
    .Clk   (Clk),
    .WrEn  (arrWrEn),
    .WrAddr(addrLat),
    .WrData(wrLat),
    .RdAddr(addrLat),
`ifdef MEM_CTRL_SYNC_PARITY_EN
    .RdPar (arrRdPar),
`endif
    .RdData(arrRdData)
  );

  // Outputs are registered: Ready, read data and error flags appear in the
  // cycle following the XFER edge, giving a latency of WAIT_CYC+1 edges after accept.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= IDLE;
      waitCnt <= '0;
      Ready   <= 1'b0;
      Busy    <= 1'b0;
      ReqErr  <= 1'b0;
      driveEn <= 1'b0;
`ifdef MEM_CTRL_SYNC_PARITY_EN
      ParErr  <= 1'b0;
`endif
    end else begin
      Ready   <= 1'b0;
      ReqErr  <= 1'b0;
      driveEn <= 1'b0;
`ifdef MEM_CTRL_SYNC_PARITY_EN
      ParErr  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (MemRd ^ MemWr) begin
            addrLat <= Addr;
            opWr    <= MemWr;
            inRange <= addrOk;
            if (MemWr) begin
              wrLat <= DataBus;
            end
            Busy <= 1'b1;
            if (WAIT_CYC > 0) begin
              state   <= WAIT;
              waitCnt <= CNT_W'(WAIT_CYC - 1);
            end else begin
              state <= XFER;
            end
          end else if (MemRd && MemWr) begin
            ReqErr <= 1'b1;
          end
        end
        WAIT: begin
          if (waitCnt == '0) begin
            state <= XFER;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end
        XFER: begin
          state  <= IDLE;
          Busy   <= 1'b0;
          Ready  <= 1'b1;
          ReqErr <= ~inRange;
          if (!opWr) begin
            driveEn <= 1'b1;
            rdOut   <= inRange ? arrRdData : '0;
`ifdef MEM_CTRL_SYNC_PARITY_EN
            ParErr  <= inRange && ((^arrRdData) != arrRdPar);
`endif
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
